soc_wb_ext_responder: RTL



---
 rtl/soc_wb_ext_responder_if.sv | 33 +++
 rtl/soc_wb_ext_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/soc_wb_ext_responder_if.sv
// Wishbone B3 bus bundle between an initiator and soc_wb_ext_responder.
// Latency: none, wires only. Backpressure: none here; stb/ack semantics come from the endpoints.
// Ports: *_i are driven by the initiator (master modport), *_o by the responder (slave modport).
interface soc_wb_ext_responder_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic            wb_cab_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i, wb_cab_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i, wb_cab_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/soc_wb_ext_responder.sv
// Wishbone B3 RAM responder: classic cycles and incrementing bursts (linear, wrap-4/8/16), err on out-of-range.
// Latency: first termination 1 + WAIT_STATES cycles after the request, then one burst beat per cycle.
// Backpressure: stb low inside a burst holds the beat address; cyc low aborts to IDLE at the next edge.
// Ports: clk, rst (synchronous, active-high), wb = slave side of soc_wb_ext_responder_if.
module soc_wb_ext_responder #(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter int            MEM_WORDS   = 1024,
  parameter logic [AW-1:0] BASE_ADDR   = '0,
  parameter int            WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  soc_wb_ext_responder_if.slave wb
);
  localparam int            NB      = DW / 8;
  localparam int            BS      = $clog2(NB);
  localparam int            MIW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW-1:0] MEM_LIM = AW'(MEM_WORDS);
  localparam logic [3:0]    WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_wcnt, w_wcnt_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic          r_below, w_below_nxt;
  logic          r_we, r_burst;
  logic [1:0]    r_bte;
  logic [DW-1:0] r_dat;
  logic          w_lat;

  // Backing store; reset never touches it.
  logic [DW-1:0] mem [MEM_WORDS];

  logic [AW-1:0] w_req_idx, w_wrap_mask, w_idx_inc, w_idx_adv;
  logic          w_req_below, w_strobe, w_ack_q, w_in_range;
  logic          w_ack, w_err, w_wr, w_load;
  logic [DW-1:0] w_rd_fwd;
  logic          w_unused;

  assign w_req_idx   = (wb.wb_adr_i - BASE_ADDR) >> BS;
  assign w_req_below = wb.wb_adr_i < BASE_ADDR;
  assign w_strobe    = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_ack_q     = (r_state == S_ACK) || (r_state == S_BURST);
  // Range is judged on the latched/advanced index, so a linear burst that runs off the end errs.
  assign w_in_range  = !r_below && (r_idx < MEM_LIM);
  assign w_ack       = w_ack_q & w_strobe & w_in_range;
  assign w_err       = w_ack_q & w_strobe & ~w_in_range;
  assign w_wr        = w_ack & r_we & ~rst;

  assign wb.wb_ack_o = w_ack;
  assign wb.wb_err_o = w_err;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = r_dat;
  assign w_unused    = wb.wb_cab_i;

  // Wrap bursts only step the low log2(N) index bits; linear steps the whole index.
  always_comb begin
    case (r_bte)
      2'b01:   w_wrap_mask = AW'(3);
      2'b10:   w_wrap_mask = AW'(7);
      2'b11:   w_wrap_mask = AW'(15);
      default: w_wrap_mask = '1;
    endcase
  end
  assign w_idx_inc = r_idx + AW'(1);
  assign w_idx_adv = (r_idx & ~w_wrap_mask) | (w_idx_inc & w_wrap_mask);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_idx_nxt   = r_idx;
    w_below_nxt = r_below;
    w_lat       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_strobe) begin
          w_lat       = 1'b1;
          w_idx_nxt   = w_req_idx;
          w_below_nxt = w_req_below;
          if (WS == 4'd0) begin
            w_state_nxt = (wb.wb_cti_i == 3'b010) ? S_BURST : S_ACK;
          end else begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt >= WS) begin
          w_state_nxt = r_burst ? S_BURST : S_ACK;
          w_wcnt_nxt  = 4'd0;
        end else begin
          w_wcnt_nxt = r_wcnt + 4'd1;
        end
      end
      S_ACK: w_state_nxt = S_IDLE;
      S_BURST: begin
        // Any non-incrementing cti on a beat closes the burst, as does an err beat.
        if (w_err || (w_ack && (wb.wb_cti_i != 3'b010))) begin
          w_state_nxt = S_IDLE;
        end else if (w_ack) begin
          w_idx_nxt = w_idx_adv;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!wb.wb_cyc_i) begin
      w_state_nxt = S_IDLE;
      w_wcnt_nxt  = 4'd0;
    end
  end

  // Read data is fetched at the edge before each beat; bytes being written on that same
  // edge to the same word are forwarded so the next beat sees the new data.
  assign w_load = ((w_state_nxt == S_ACK) || (w_state_nxt == S_BURST)) &&
                  !w_below_nxt && (w_idx_nxt < MEM_LIM);

  always_comb begin
    w_rd_fwd = mem[w_idx_nxt[MIW-1:0]];
    for (int b = 0; b < NB; b++) begin
      if (w_wr && (w_idx_nxt == r_idx) && wb.wb_sel_i[b]) begin
        w_rd_fwd[b*8 +: 8] = wb.wb_dat_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= 4'd0;
      r_idx   <= '0;
      r_below <= 1'b0;
      r_we    <= 1'b0;
      r_burst <= 1'b0;
      r_bte   <= 2'b00;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_idx   <= w_idx_nxt;
      r_below <= w_below_nxt;
      if (w_lat) begin
        r_we    <= wb.wb_we_i;
        r_burst <= (wb.wb_cti_i == 3'b010);
        r_bte   <= wb.wb_bte_i;
      end
      if (w_load) begin
        r_dat <= w_rd_fwd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (wb.wb_sel_i[b]) begin
          mem[r_idx[MIW-1:0]][b*8 +: 8] <= wb.wb_dat_i[b*8 +: 8];
        end
      end
    end
  end
endmodule
